// File: rtl/pipe_ctrl_gen.sv
// Pipeline hazard controller: merges stage stall requests, bus stall and
// redirect flushes into per-stage stall/flush, plus stall watchdog and counter.
module pipe_ctrl_gen #(
    parameter int STAGES    = 6,
    parameter int PC_W      = 32,
    parameter int FLUSH_CYC = 1,
    parameter int WD_LIMIT  = 1024,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq,
    input  logic              stallreq_axi,
    input  logic              flush_req,
    input  logic [PC_W-1:0]   flush_pc,
    input  logic              wd_clr,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] flush,
    output logic              new_pc_vld,
    output logic [PC_W-1:0]   new_pc,
    output logic              wd_trip,
    output logic [CNT_W-1:0]  stall_cycles
);
    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam int WD_W = $clog2(WD_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, PEND, FLUSH} state_t;

    state_t            state, state_n;
    logic [FC_W-1:0]   fcnt, fcnt_n;
    logic              first, first_n;
    logic [PC_W-1:0]   pc_q, pc_n;
    logic [WD_W-1:0]   wd_cnt;
    logic [STAGES-1:0] req_mask, bubble;

    // A request at stage k holds 0..k; the stage just above gets a bubble.
    genvar i;
    generate
        for (i = 0; i < STAGES; i++) begin : g_stage
            assign req_mask[i] = |stallreq[STAGES-1:i];
            if (i == 0) begin : g_pc
                assign bubble[i] = 1'b0;
            end else begin : g_up
                assign bubble[i] = req_mask[i-1] & ~req_mask[i];
            end
        end
    endgenerate

    always_comb begin
        stall      = req_mask;
        flush      = bubble;
        if (state == FLUSH) begin
            stall = '0;
            flush = '1;
        end
        if (stallreq_axi) begin
            stall = '1;
            flush = '0;
        end
        new_pc_vld = (state == FLUSH) && first && !stallreq_axi;
        new_pc     = pc_q;
    end

    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        first_n = first;
        pc_n    = pc_q;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    pc_n    = flush_pc;
                    fcnt_n  = '0;
                    first_n = 1'b1;
                    state_n = stallreq_axi ? PEND : FLUSH;
                end
            end
            PEND: begin
                if (flush_req) pc_n = flush_pc;
                if (!stallreq_axi) begin
                    fcnt_n  = '0;
                    first_n = 1'b1;
                    state_n = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_req) begin
                    pc_n    = flush_pc;
                    fcnt_n  = '0;
                    first_n = 1'b1;
                end else if (!stallreq_axi) begin
                    // bus stall freezes the hold count; otherwise advance
                    first_n = 1'b0;
                    if (fcnt == FC_W'(FLUSH_CYC - 1)) state_n = IDLE;
                    else                              fcnt_n  = fcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            fcnt  <= '0;
            first <= 1'b0;
            pc_q  <= '0;
        end else begin
            state <= state_n;
            fcnt  <= fcnt_n;
            first <= first_n;
            pc_q  <= pc_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt       <= '0;
            wd_trip      <= 1'b0;
            stall_cycles <= '0;
        end else if (wd_clr) begin
            wd_cnt       <= '0;
            wd_trip      <= 1'b0;
            stall_cycles <= '0;
        end else if (stall[0]) begin
            if (wd_cnt != WD_W'(WD_LIMIT))     wd_cnt  <= wd_cnt + 1'b1;
            if (wd_cnt == WD_W'(WD_LIMIT - 1)) wd_trip <= 1'b1;
            if (!(&stall_cycles))              stall_cycles <= stall_cycles + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Scoreboard bench for pipe_ctrl_gen: driver queues hand-computed expectations
// per cycle, a negedge monitor pops and compares against the DUT outputs.
module tb_pipe_ctrl_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stallreq = '0;
    logic        stallreq_axi = 1'b0;
    logic        flush_req = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        wd_clr = 1'b0;
    logic [5:0]  stall, flush;
    logic        new_pc_vld;
    logic [31:0] new_pc;
    logic        wd_trip;
    logic [31:0] stall_cycles;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [5:0]  st;
        logic [5:0]  fl;
        bit          cp;
        logic        vld;
        logic [31:0] pc;
        bit          cw;
        logic        trip;
        logic [31:0] cnt;
        int          id;
    } exp_t;

    exp_t q[$];
    int   cyc_id = 0;

    pipe_ctrl_gen #(.STAGES(6), .PC_W(32), .FLUSH_CYC(2), .WD_LIMIT(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stallreq(stallreq), .stallreq_axi(stallreq_axi),
        .flush_req(flush_req), .flush_pc(flush_pc), .wd_clr(wd_clr),
        .stall(stall), .flush(flush), .new_pc_vld(new_pc_vld), .new_pc(new_pc),
        .wd_trip(wd_trip), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall", e.id, {26'd0, stall}, {26'd0, e.st});
            chk("flush", e.id, {26'd0, flush}, {26'd0, e.fl});
            if (e.cp) begin
                chk("new_pc_vld", e.id, {31'd0, new_pc_vld}, {31'd0, e.vld});
                chk("new_pc", e.id, new_pc, e.pc);
            end
            if (e.cw) begin
                chk("wd_trip", e.id, {31'd0, wd_trip}, {31'd0, e.trip});
                chk("stall_cycles", e.id, stall_cycles, e.cnt);
            end
        end
    end

    // Drive one cycle's inputs just after the rising edge and queue what the
    // outputs must show at the following falling edge.
    task automatic cyc(input logic r, input logic [5:0] sr, input logic axi, input logic fr,
                       input logic [31:0] fpc, input logic clr,
                       input logic [5:0] es, input logic [5:0] ef,
                       input bit cp, input logic ev, input logic [31:0] epc,
                       input bit cw, input logic et, input logic [31:0] ec);
        exp_t e;
        rst = r; stallreq = sr; stallreq_axi = axi; flush_req = fr; flush_pc = fpc; wd_clr = clr;
        e.st = es; e.fl = ef; e.cp = cp; e.vld = ev; e.pc = epc;
        e.cw = cw; e.trip = et; e.cnt = ec; e.id = cyc_id;
        q.push_back(e);
        cyc_id++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // reset state
        cyc(1, 6'b0, 0, 0, 0, 0, 6'b0, 6'b0, 1, 0, 0, 1, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0, 6'b0, 6'b0, 1, 0, 0, 1, 0, 0);
        // stall vector decode
        cyc(0, 6'b000100, 0, 0, 0, 0, 6'b000111, 6'b001000, 0, 0, 0, 0, 0, 0);
        cyc(0, 6'b000001, 0, 0, 0, 0, 6'b000001, 6'b000010, 0, 0, 0, 0, 0, 0);
        cyc(0, 6'b010010, 0, 0, 0, 0, 6'b011111, 6'b100000, 0, 0, 0, 0, 0, 0);
        cyc(0, 6'b100000, 0, 0, 0, 0, 6'b111111, 6'b000000, 0, 0, 0, 0, 0, 0);
        cyc(0, 6'b000000, 0, 0, 0, 0, 6'b000000, 6'b000000, 0, 0, 0, 0, 0, 0);
        // flush, held 2 cycles; flush overrides stallreq
        cyc(0, 6'b0, 0, 1, 32'h8000_0100, 0, 6'b0, 6'b0, 1, 0, 0, 0, 0, 0);
        cyc(0, 6'b000100, 0, 0, 0, 0, 6'b0, 6'b111111, 1, 1, 32'h8000_0100, 0, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0, 6'b0, 6'b111111, 1, 0, 32'h8000_0100, 0, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0, 6'b0, 6'b0, 1, 0, 32'h8000_0100, 0, 0, 0);
        // flush deferred by a 5-cycle bus stall; later request wins
        cyc(0, 6'b001100, 1, 1, 32'h1234_0000, 0, 6'b111111, 6'b0, 1, 0, 32'h8000_0100, 0, 0, 0);
        cyc(0, 6'b0, 1, 0, 0, 0, 6'b111111, 6'b0, 1, 0, 32'h1234_0000, 0, 0, 0);
        cyc(0, 6'b0, 1, 1, 32'h0000_2000, 0, 6'b111111, 6'b0, 1, 0, 32'h1234_0000, 0, 0, 0);
        cyc(0, 6'b0, 1, 0, 0, 0, 6'b111111, 6'b0, 1, 0, 32'h0000_2000, 0, 0, 0);
        cyc(0, 6'b0, 1, 0, 0, 0, 6'b111111, 6'b0, 1, 0, 32'h0000_2000, 0, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0, 6'b0, 6'b0, 1, 0, 32'h0000_2000, 0, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0, 6'b0, 6'b111111, 1, 1, 32'h0000_2000, 0, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0, 6'b0, 6'b111111, 1, 0, 32'h0000_2000, 0, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0, 6'b0, 6'b0, 1, 0, 32'h0000_2000, 0, 0, 0);
        // bus stall inside FLUSH freezes the hold count
        cyc(0, 6'b0, 0, 1, 32'h0000_0040, 0, 6'b0, 6'b0, 1, 0, 32'h0000_2000, 0, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0, 6'b0, 6'b111111, 1, 1, 32'h0000_0040, 0, 0, 0);
        cyc(0, 6'b0, 1, 0, 0, 0, 6'b111111, 6'b0, 1, 0, 32'h0000_0040, 0, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0, 6'b0, 6'b111111, 1, 0, 32'h0000_0040, 0, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0, 6'b0, 6'b0, 1, 0, 32'h0000_0040, 0, 0, 0);
        // watchdog: clear, 8 stalled cycles trip it, clear again
        cyc(0, 6'b0, 0, 0, 0, 1, 6'b0, 6'b0, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 8; j++)
            cyc(0, 6'b0, 1, 0, 0, 0, 6'b111111, 6'b0, 0, 0, 0, 1, 0, j);
        cyc(0, 6'b0, 0, 0, 0, 1, 6'b0, 6'b0, 0, 0, 0, 1, 1, 8);
        cyc(0, 6'b0, 0, 0, 0, 0, 6'b0, 6'b0, 0, 0, 0, 1, 0, 0);
        // reset in the middle of FLUSH, then a clean redirect
        cyc(0, 6'b0, 0, 1, 32'h0000_0055, 0, 6'b0, 6'b0, 1, 0, 32'h0000_0040, 0, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0, 6'b0, 6'b111111, 1, 1, 32'h0000_0055, 0, 0, 0);
        cyc(1, 6'b0, 0, 0, 0, 0, 6'b0, 6'b0, 1, 0, 0, 1, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0, 6'b0, 6'b0, 1, 0, 0, 1, 0, 0);
        cyc(0, 6'b0, 0, 1, 32'h8000_0100, 0, 6'b0, 6'b0, 1, 0, 0, 0, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0, 6'b0, 6'b111111, 1, 1, 32'h8000_0100, 0, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0, 6'b0, 6'b111111, 1, 0, 32'h8000_0100, 0, 0, 0);
        cyc(0, 6'b0, 0, 0, 0, 0, 6'b0, 6'b0, 1, 0, 32'h8000_0100, 0, 0, 0);
        // bounded drain of the scoreboard
        for (int t = 0; t < 4 && q.size() > 0; t++) @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
